uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised asynchronous UART transmitter for the iCEBreaker communication blocks. It supports configurable data width, parity mode and stop-bit count. A one-word holding register behind a valid/ready handshake allows back-to-back frames with no idle gap. It sits between any byte/word producer (command encoder, FIFO, debug bridge) and the board's serial TX pin.

## Interface
Parameters:
- `CLK_FREQ`, 12000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s. `DIV = (CLK_FREQ + BAUD/2) / BAUD` clocks per bit. `DIV >= 2` is required (elaboration error otherwise).
- `DATA_BITS`, 8: payload width, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even. Other values are an elaboration error.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_valid`  in  1  producer has a word on `tx_data`.
- `tx_data`  in  DATA_BITS  word to send, LSB first.
- `tx_ready`  out  1  holding register empty; the word is accepted on the edge where `tx_valid & tx_ready`.
- `tx`  out  1  serial line, idle high, registered (glitch-free).
- `tx_busy`  out  1  high while a frame is on the line or a word is held.

## Operation
- Handshake:
  - Accepted word goes into the holding register `hold`, and `hold_full` sets.
  - `tx_ready = ~hold_full`.
  - `tx_data` may change freely when not accepted.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: `tx`=1. If `hold_full`, go to START. In the same edge, load shifter from `hold`, clear `hold_full`, compute parity bit, clear baud counter.
  - START: `tx`=0 for one bit period. Then go to DATA, bit index 0.
  - DATA: `tx` = shifter[0]. Shift right each bit tick. After DATA_BITS ticks, go to PAR if `PARITY != 0`, else STOP.
  - PAR: `tx` = parity bit for one bit period.
    - Even parity: XOR of data.
    - Odd parity: inverted XOR of data.
  - STOP: `tx`=1 for STOP_BITS bit periods.
    - On the final tick, if `hold_full`, go directly to START with the same load actions as IDLE (zero-gap chaining).
    - Otherwise go to IDLE.
- Baud counter:
  - Counts 0..DIV-1 while not IDLE.
  - Bit tick when the count is DIV-1, then the counter wraps to 0.
  - Forced to 0 on frame start, so every bit lasts exactly DIV clocks.
- The producer may refill `hold` at any time during a frame, including the final stop-tick edge. On that edge, loading from `hold` takes precedence and `hold_full` reflects the new word.
- `tx_busy = (state != IDLE) | hold_full`.
- Widths:
  - Bit index counter is `$clog2(DATA_BITS+1)` bits.
  - Baud counter is `$clog2(DIV)` bits.
  - No truncation of `tx_data`.

## Timing
- Reset (async, immediate): state IDLE, `tx`=1, `hold_full`=0, `tx_ready`=1, `tx_busy`=0, counters 0.
- Reset mid-frame aborts the frame. The line goes high at once and the held word is discarded.
- Latency:
  - Word accepted at edge k into an idle block.
  - `hold_full`=1 after k.
  - START entered and `tx` falls after edge k+1.
- Frame length is `DIV*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS)` clocks, exactly.
- Chained frames: the start bit begins on the clock right after the last stop period. There are no extra idle cycles.
- `tx_ready` falls the edge after acceptance. It rises the edge the FSM loads the shifter.
- A `tx_valid` held high while `tx_ready`=0 is not accepted and is not lost. It is accepted on the first edge where `tx_ready`=1.

## Structure
- Shared package `uart_pkg`:
  - Parity constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`.
  - FSM state encoding.
  - Function `uart_div(clk_freq, baud)` returning the rounded divider.
  - This package is reused by the matching RX block.
- Sub-module `uart_baud_div`:
  - Inputs: `clk`, `rst`, `clear`, `enable`.
  - Output: one-cycle `tick`.
  - Parameter `DIV`.
  - Instantiated once.

## Test plan
Bench uses CLK_FREQ=400, BAUD=100 (DIV=4) unless noted.
- 8N1, send 0x55: `tx` low 4 clks, then 1,0,1,0,1,0,1,0 (LSB first, 4 clks each), then high 4 clks. Frame = 40 clks. `tx_busy` drops after it.
- 7E2 (DATA_BITS=7, PARITY=2, STOP_BITS=2), send 0x13 (three ones): parity bit=1, two stop bits. Frame = 44 clks. Then 0x03: parity bit=0.
- 9O1, send 0x1FF: parity bit=0 (nine ones, already odd). Send 0x000: parity bit=1.
- Back-to-back: `tx_valid` held high with 0xA5, 0x3C, 0xFF. Second word accepted 1 clk after the first loads. Start bits at clks 0, 40, 80 relative to the first start. No idle gaps.
- Reset asserted at clk 17 of a frame with a word held: `tx`=1 and `tx_ready`=1 immediately. After release, no frame is sent until a new `tx_valid`.
- CLK_FREQ=12000000, BAUD=115200: DIV=104. Each bit period measures exactly 104 clks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX blocks.
// Holds parity-mode constants, FSM state encoding and the baud divider helper.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int uart_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last count.
// tick is combinational from the count register, high for one clock per period.
// No flow control; clear restarts the period so the next bit lasts exactly DIV clocks.
module uart_baud_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable & (cnt == LAST);

    // Period counter: clear has priority, wraps to zero on the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Latency: word accepted at edge k, start bit on the line after edge k+1.
// Backpressure: one-word holding register; tx_ready low while it is occupied.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int DIV   = uart_div(CLK_FREQ, BAUD);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_frame: CLK_FREQ/BAUD gives DIV < 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    uart_state_t          state, state_n;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shifter, shift_n;
    logic [IDX_W-1:0]     bit_idx, idx_n;
    logic                 stop_cnt, stop_n;
    logic                 par_bit, par_n;
    logic                 tx_q, tx_n;
    logic                 load;
    logic                 tick;
    logic                 accept;

    assign accept   = tx_valid & ~hold_full;
    assign tx_ready = ~hold_full;
    assign tx       = tx_q;
    assign tx_busy  = (state != ST_IDLE) | hold_full;

    uart_baud_div #(
        .DIV (DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (load),
        .enable (state != ST_IDLE),
        .tick   (tick)
    );

    // Next-state, shifter and line-level decode; tx is precomputed for the next state.
    always_comb begin
        state_n = state;
        shift_n = shifter;
        idx_n   = bit_idx;
        stop_n  = stop_cnt;
        par_n   = par_bit;
        load    = 1'b0;
        tx_n    = 1'b1;

        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_n = ST_DATA;
                    idx_n   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_n = shifter >> 1;
                    if (bit_idx == IDX_LAST) begin
                        state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        stop_n  = 1'b0;
                    end else begin
                        idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            ST_PAR: begin
                if (tick) begin
                    state_n = ST_STOP;
                    stop_n  = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        // A waiting word starts immediately: no idle bit between frames.
                        if (hold_full) begin
                            load    = 1'b1;
                            state_n = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (load) begin
            shift_n = hold;
            par_n   = (PARITY == PAR_EVEN) ? (^hold) : ~(^hold);
        end

        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = shift_n[0];
            ST_PAR:   tx_n = par_n;
            default:  tx_n = 1'b1;
        endcase
    end

    // Frame state registers; tx is registered so the line never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shifter  <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            shifter  <= shift_n;
            bit_idx  <= idx_n;
            stop_cnt <= stop_n;
            par_bit  <= par_n;
            tx_q     <= tx_n;
        end
    end

    // Holding register: filled on handshake, emptied when the FSM loads the shifter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

endmodule
